// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: load funct3 encodings,
// the queued-result entry format and default sizing.
package wb_pkg;

    localparam int WB_XLEN           = 32;
    localparam int LSU_DEPTH_DEFAULT = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]         rd_addr;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of formatted load results. Exposes the head entry
// combinationally plus per-slot valid/rd so the parent can build a hazard mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = LSU_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic [$clog2(DEPTH):0]      count,
    output logic [DEPTH-1:0]            slot_valid,
    output logic [DEPTH-1:0][4:0]       slot_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q,  count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: slot validity is derived purely from pointers/count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [AW-1:0] rel;
            assign rel            = IDX - rd_ptr_q;
            assign slot_valid[gi] = ({1'b0, rel} < count_q);
            assign slot_rd[gi]    = mem_q[gi].rd_addr;
        end
    endgenerate

    assert property (@(posedge clk) disable iff (srst) !(push && count_q == FULL));
    assert property (@(posedge clk) disable iff (srst) count_q <= FULL);

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: arbitrates ALU results and formatted load returns onto the
// single regfile write port, queueing loads that lose and publishing a pending mask.
module wb_writeback
    import wb_pkg::*;
#(
    parameter int LSU_DEPTH = LSU_DEPTH_DEFAULT,
    parameter int XLEN      = WB_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd_addr,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic [4:0]      i_lsu_rd_addr,
    input  logic [2:0]      i_lsu_funct3,
    input  logic [1:0]      i_lsu_byte_off,
    input  logic [XLEN-1:0] i_lsu_rdata,
    output logic            o_rd_wren,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic [31:0]     o_pending_mask
);

    localparam int AW = $clog2(LSU_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(LSU_DEPTH);

    logic [XLEN-1:0] load_fmt;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    logic            alu_win, lsu_acc, lsu_keep;
    logic            fifo_empty, fifo_push, fifo_pop, bypass;
    wb_entry_t       fifo_head, push_entry;
    logic [AW:0]     fifo_count;
    logic [LSU_DEPTH-1:0]      slot_valid;
    logic [LSU_DEPTH-1:0][4:0] slot_rd;

    logic            rd_wren_q, rd_wren_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    always_comb begin
        byte_sel = i_lsu_rdata[7:0];
        case (i_lsu_byte_off)
            2'd0: byte_sel = i_lsu_rdata[7:0];
            2'd1: byte_sel = i_lsu_rdata[15:8];
            2'd2: byte_sel = i_lsu_rdata[23:16];
            2'd3: byte_sel = i_lsu_rdata[31:24];
            default: byte_sel = i_lsu_rdata[7:0];
        endcase
        half_sel = i_lsu_byte_off[1] ? i_lsu_rdata[31:16] : i_lsu_rdata[15:0];
        case (i_lsu_funct3)
            F3_LB:   load_fmt = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  load_fmt = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   load_fmt = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  load_fmt = {{(XLEN-16){1'b0}}, half_sel};
            default: load_fmt = i_lsu_rdata;
        endcase
    end

    assign o_lsu_ready = !i_rst && (fifo_count < FULL);
    assign fifo_empty  = (fifo_count == '0);
    assign alu_win     = i_alu_valid && (i_alu_rd_addr != 5'd0);
    assign lsu_acc     = i_lsu_valid && o_lsu_ready;
    // x0 loads complete the handshake but are otherwise dropped here.
    assign lsu_keep    = lsu_acc && (i_lsu_rd_addr != 5'd0);
    assign fifo_pop    = !alu_win && !fifo_empty;
    assign bypass      = !alu_win && fifo_empty && lsu_keep;
    assign fifo_push   = lsu_keep && !bypass;

    assign push_entry.rd_addr = i_lsu_rd_addr;
    assign push_entry.data    = load_fmt;

    wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
        .clk        (i_clk),
        .srst       (i_rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .slot_valid (slot_valid),
        .slot_rd    (slot_rd)
    );

    always_comb begin
        rd_wren_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (alu_win) begin
            rd_wren_d = 1'b1;
            rd_addr_d = i_alu_rd_addr;
            rd_data_d = i_alu_data;
        end else if (fifo_pop) begin
            rd_wren_d = 1'b1;
            rd_addr_d = fifo_head.rd_addr;
            rd_data_d = fifo_head.data;
        end else if (bypass) begin
            rd_wren_d = 1'b1;
            rd_addr_d = i_lsu_rd_addr;
            rd_data_d = load_fmt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_wren_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign o_rd_wren = rd_wren_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rd_data = rd_data_q;

    always_comb begin
        o_pending_mask = '0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            if (slot_valid[i]) o_pending_mask[slot_rd[i]] = 1'b1;
        end
        if (rd_wren_q) o_pending_mask[rd_addr_q] = 1'b1;
        o_pending_mask[0] = 1'b0;
    end

    // Decode must stall an ALU op whose destination still has a write in flight.
    assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_alu_valid && o_pending_mask[i_alu_rd_addr]));

endmodule

// File: tb/tb_wb_writeback.sv
// Directed bench for wb_writeback: reset, ALU path, load formatting,
// arbitration/queueing order, backpressure and reset discard.
module tb_wb_writeback;
    import wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [2:0]  lsu_f3;
    logic [1:0]  lsu_off;
    logic [31:0] lsu_rdata;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] pend;

    int n_tests = 0;
    int n_fail  = 0;

    wb_writeback #(.LSU_DEPTH(2), .XLEN(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_alu_valid    (alu_valid),
        .i_alu_rd_addr  (alu_rd),
        .i_alu_data     (alu_data),
        .i_lsu_valid    (lsu_valid),
        .o_lsu_ready    (lsu_ready),
        .i_lsu_rd_addr  (lsu_rd),
        .i_lsu_funct3   (lsu_f3),
        .i_lsu_byte_off (lsu_off),
        .i_lsu_rdata    (lsu_rdata),
        .o_rd_wren      (rd_wren),
        .o_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .o_pending_mask (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
            $display("[TB] ok   %-14s = 0x%08h", tag, obs);
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".wren"}, {31'd0, rd_wren}, 32'd1);
        chk({tag, ".addr"}, {27'd0, rd_addr}, {27'd0, a});
        chk({tag, ".data"}, rd_data, d);
    endtask

    logic [2:0]  f3_tab  [8] = '{F3_LB, F3_LB, F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, 3'b011};
    logic [1:0]  off_tab [8] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2};
    logic [31:0] exp_tab [8] = '{32'h00000001, 32'h0000007F, 32'hFFFFFF80, 32'h00000080,
                                 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01, 32'h80FF7F01};

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_f3 = '0; lsu_off = '0; lsu_rdata = '0;

        // Reset then idle
        tick(); tick();
        chk("rst.wren",  {31'd0, rd_wren}, 32'd0);
        chk("rst.addr",  {27'd0, rd_addr}, 32'd0);
        chk("rst.data",  rd_data, 32'd0);
        chk("rst.ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst.mask",  pend, 32'd0);
        rst = 1'b0;
        #1;
        chk("post.ready", {31'd0, lsu_ready}, 32'd1);
        chk("post.mask",  pend, 32'd0);

        // ALU write, one-cycle pulse, then x0 drop
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h12345678;
        tick();
        chk_wr("alu5", 5'd5, 32'h12345678);
        chk("alu5.mask", pend, 32'h00000020);
        alu_valid = 1'b0;
        tick();
        chk("alu5.n2", {31'd0, rd_wren}, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        chk("alu0.wren", {31'd0, rd_wren}, 32'd0);
        tick();
        chk("alu0.n2", {31'd0, rd_wren}, 32'd0);

        // Load formatting through the bypass path
        lsu_rdata = 32'h80FF7F01;
        for (int i = 0; i < 8; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(i + 1); lsu_f3 = f3_tab[i]; lsu_off = off_tab[i];
            chk($sformatf("fmt%0d.ready", i), {31'd0, lsu_ready}, 32'd1);
            tick();
            chk_wr($sformatf("fmt%0d", i), 5'(i + 1), exp_tab[i]);
        end
        lsu_valid = 1'b0;
        tick();
        chk("fmt.idle", {31'd0, rd_wren}, 32'd0);

        // ALU and LSU in the same cycle: ALU wins, load queued
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_f3 = F3_LW; lsu_off = 2'd0; lsu_rdata = 32'hA;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk_wr("arb.x3", 5'd3, 32'h33);
        chk("arb.mask1", pend, 32'h00000088);
        tick();
        chk_wr("arb.x7", 5'd7, 32'hA);
        chk("arb.mask2", pend, 32'h00000080);
        tick();
        chk("arb.idle", {31'd0, rd_wren}, 32'd0);
        chk("arb.mask3", pend, 32'd0);

        // Three ALU cycles with three loads: backpressure then in-order drain
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA10;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_rdata = 32'h1111_0001; lsu_f3 = F3_LW;
        tick();
        chk_wr("bp.x10", 5'd10, 32'hA10);
        alu_rd = 5'd11; alu_data = 32'hA11;
        lsu_rd = 5'd21; lsu_rdata = 32'h2222_0002;
        chk("bp.ready1", {31'd0, lsu_ready}, 32'd1);
        tick();
        chk_wr("bp.x11", 5'd11, 32'hA11);
        chk("bp.mask", pend, 32'h00300800);
        chk("bp.ready2", {31'd0, lsu_ready}, 32'd0);
        alu_rd = 5'd12; alu_data = 32'hA12;
        lsu_rd = 5'd22; lsu_rdata = 32'h3333_0003;
        tick();
        chk_wr("bp.x12", 5'd12, 32'hA12);
        chk("bp.mask2", pend, 32'h00301000);
        chk("bp.ready3", {31'd0, lsu_ready}, 32'd0);
        alu_valid = 1'b0;
        tick();
        chk_wr("bp.x20", 5'd20, 32'h1111_0001);
        chk("bp.ready4", {31'd0, lsu_ready}, 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk_wr("bp.x21", 5'd21, 32'h2222_0002);
        chk("bp.mask3", pend, 32'h00600000);
        tick();
        chk_wr("bp.x22", 5'd22, 32'h3333_0003);
        chk("bp.mask4", pend, 32'h00400000);
        tick();
        chk("bp.idle", {31'd0, rd_wren}, 32'd0);
        chk("bp.mask5", pend, 32'd0);

        // Queue two loads, glitch reset between edges, then real reset
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hA13;
        lsu_valid = 1'b1; lsu_rd = 5'd24; lsu_rdata = 32'h24;
        tick();
        alu_rd = 5'd14; alu_data = 32'hA14;
        lsu_rd = 5'd25; lsu_rdata = 32'h25;
        tick();
        chk_wr("q.x14", 5'd14, 32'hA14);
        chk("q.mask", pend, 32'h03004000);
        alu_rd = 5'd15; alu_data = 32'hA15;
        lsu_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        chk_wr("glitch.x15", 5'd15, 32'hA15);
        chk("glitch.mask", pend, 32'h03008000);
        alu_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("srst.ready", {31'd0, lsu_ready}, 32'd0);
        tick();
        chk("srst.wren", {31'd0, rd_wren}, 32'd0);
        chk("srst.addr", {27'd0, rd_addr}, 32'd0);
        chk("srst.data", rd_data, 32'd0);
        chk("srst.mask", pend, 32'd0);
        rst = 1'b0;
        #1;
        chk("srst.ready2", {31'd0, lsu_ready}, 32'd1);
        tick();
        chk("srst.nowr1", {31'd0, rd_wren}, 32'd0);
        chk("srst.mask2", pend, 32'd0);
        tick();
        chk("srst.nowr2", {31'd0, rd_wren}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
